// File: rtl/cart_pkg.sv
// Shared types and constants for the cartridge memory arbiter.
package cart_pkg;

  localparam int         ADDR_W   = 25;
  localparam logic [7:0] OPEN_BUS = 8'hFF;

  typedef enum logic [1:0] {
    OWN_LD,
    OWN_A,
    OWN_B
  } owner_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_t;

endpackage

// File: rtl/cart_rr_pick.sv
// Two-way round-robin between cartridge slot A and slot B.
// The pointer names the slot favoured on contention and flips to the
// other slot whenever a slot grant is taken (en high).
module cart_rr_pick (
  input  logic clk,
  input  logic reset_n,
  input  logic a_vld,
  input  logic b_vld,
  input  logic en,
  output logic gnt_a,
  output logic gnt_b
);

  logic ptr_b_q;
  logic ptr_b_d;

  // lone requester wins; contention resolved by the pointer
  always_comb begin
    gnt_a   = a_vld && (!b_vld || !ptr_b_q);
    gnt_b   = b_vld && (!a_vld || ptr_b_q);
    ptr_b_d = ptr_b_q;
    if (en && gnt_a) begin
      ptr_b_d = 1'b1;
    end else if (en && gnt_b) begin
      ptr_b_d = 1'b0;
    end
  end

  // pointer register, favours slot A out of reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_b_q <= 1'b0;
    end else begin
      ptr_b_q <= ptr_b_d;
    end
  end

endmodule

// File: rtl/cart_mem_arbiter.sv
// Shares the cartridge backing memory between the ROM loader and the two
// cartridge slots. One access in flight at a time; slot reads beyond the
// loaded image size are answered locally with open-bus data.
//
//   state | meaning
//   IDLE  | pick next requester, answer out-of-range slot reads directly
//   ISSUE | first cycle of mem_req for the latched access
//   WAIT  | hold mem_req until mem_ack or watchdog expiry
module cart_mem_arbiter
  import cart_pkg::*;
#(
  parameter int TIMEOUT_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              ld_ack,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [ADDR_W-1:0] a_size,
  output logic              a_ack,
  output logic [7:0]        a_data,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [ADDR_W-1:0] b_size,
  output logic              b_ack,
  output logic [7:0]        b_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic              mem_ack,
  input  logic [7:0]        mem_dout,
  output logic              timeout
);

  // last WAIT count before expiry: expiry lands on the (2**TIMEOUT_W-1)th WAIT cycle
  localparam logic [TIMEOUT_W-1:0] WDOG_LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [7:0]        mem_din_q, mem_din_d;
  logic              mem_req_q, mem_req_d;
  logic              ld_ack_q, ld_ack_d;
  logic              a_ack_q, a_ack_d;
  logic              b_ack_q, b_ack_d;
  logic [7:0]        a_data_q, a_data_d;
  logic [7:0]        b_data_q, b_data_d;
  logic              timeout_q, timeout_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;

  logic       ld_vld, a_vld, b_vld;
  logic       gnt_a, gnt_b, pick_en;
  logic       done;
  logic [7:0] done_data;

  // a request is ignored in the cycle its own ack is driven
  assign ld_vld  = ld_req && !ld_ack_q;
  assign a_vld   = a_req && !a_ack_q;
  assign b_vld   = b_req && !b_ack_q;
  assign pick_en = (state_q == IDLE) && !ld_vld;

  cart_rr_pick u_rr_pick (
    .clk     (clk),
    .reset_n (reset_n),
    .a_vld   (a_vld),
    .b_vld   (b_vld),
    .en      (pick_en),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b)
  );

  // next-state, grant, range check, watchdog and completion
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    mem_addr_d = mem_addr_q;
    mem_we_d   = mem_we_q;
    mem_din_d  = mem_din_q;
    mem_req_d  = mem_req_q;
    ld_ack_d   = 1'b0;
    a_ack_d    = 1'b0;
    b_ack_d    = 1'b0;
    a_data_d   = a_data_q;
    b_data_d   = b_data_q;
    timeout_d  = timeout_q;
    wdog_d     = wdog_q;
    done       = 1'b0;
    done_data  = OPEN_BUS;

    case (state_q)
      IDLE: begin
        if (ld_vld) begin
          owner_d    = OWN_LD;
          mem_addr_d = ld_addr;
          mem_we_d   = 1'b1;
          mem_din_d  = ld_data;
          mem_req_d  = 1'b1;
          state_d    = ISSUE;
        end else if (gnt_a) begin
          if (a_addr >= a_size) begin
            a_ack_d  = 1'b1;
            a_data_d = OPEN_BUS;
          end else begin
            owner_d    = OWN_A;
            mem_addr_d = a_addr;
            mem_we_d   = 1'b0;
            mem_req_d  = 1'b1;
            state_d    = ISSUE;
          end
        end else if (gnt_b) begin
          if (b_addr >= b_size) begin
            b_ack_d  = 1'b1;
            b_data_d = OPEN_BUS;
          end else begin
            owner_d    = OWN_B;
            mem_addr_d = b_addr;
            mem_we_d   = 1'b0;
            mem_req_d  = 1'b1;
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (mem_ack) begin
          done      = 1'b1;
          done_data = mem_dout;
        end else if (wdog_q == WDOG_LAST) begin
          done      = 1'b1;
          timeout_d = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (done) begin
      mem_req_d = 1'b0;
      state_d   = IDLE;
      case (owner_q)
        OWN_LD: ld_ack_d = 1'b1;
        OWN_A: begin
          a_ack_d  = 1'b1;
          a_data_d = done_data;
        end
        OWN_B: begin
          b_ack_d  = 1'b1;
          b_data_d = done_data;
        end
        default: ;
      endcase
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      owner_q    <= OWN_LD;
      mem_addr_q <= '0;
      mem_we_q   <= 1'b0;
      mem_din_q  <= '0;
      mem_req_q  <= 1'b0;
      ld_ack_q   <= 1'b0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      a_data_q   <= OPEN_BUS;
      b_data_q   <= OPEN_BUS;
      timeout_q  <= 1'b0;
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      mem_addr_q <= mem_addr_d;
      mem_we_q   <= mem_we_d;
      mem_din_q  <= mem_din_d;
      mem_req_q  <= mem_req_d;
      ld_ack_q   <= ld_ack_d;
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
      a_data_q   <= a_data_d;
      b_data_q   <= b_data_d;
      timeout_q  <= timeout_d;
      wdog_q     <= wdog_d;
    end
  end

  assign ld_ack   = ld_ack_q;
  assign a_ack    = a_ack_q;
  assign b_ack    = b_ack_q;
  assign a_data   = a_data_q;
  assign b_data   = b_data_q;
  assign mem_req  = mem_req_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Bench for cart_mem_arbiter: requester agents driven from job queues, a
// behavioural SDRAM responder, and a transaction-level expectation model.
module tb_cart_mem_arbiter;
  import cart_pkg::*;

  localparam int TW       = 5;
  localparam int WDOG_CYC = (1 << TW) - 1;

  typedef struct {
    logic [24:0] addr;
    logic [24:0] size;
    logic [7:0]  data;
    bit          exp_to;
  } job_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  req_v;
  logic [24:0] addr_v [3];
  logic [24:0] size_v [3];
  logic [7:0]  ld_data;
  logic        ld_ack, a_ack, b_ack;
  logic [7:0]  a_data, b_data;
  logic        mem_req, mem_we, mem_ack, timeout;
  logic [24:0] mem_addr;
  logic [7:0]  mem_din, mem_dout;
  wire  [2:0]  ack_w = {b_ack, a_ack, ld_ack};

  cart_mem_arbiter #(.TIMEOUT_W(TW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ld_req   (req_v[0]),
    .ld_addr  (addr_v[0]),
    .ld_data  (ld_data),
    .ld_ack   (ld_ack),
    .a_req    (req_v[1]),
    .a_addr   (addr_v[1]),
    .a_size   (size_v[1]),
    .a_ack    (a_ack),
    .a_data   (a_data),
    .b_req    (req_v[2]),
    .b_addr   (addr_v[2]),
    .b_size   (size_v[2]),
    .b_ack    (b_ack),
    .b_data   (b_data),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_ack  (mem_ack),
    .mem_dout (mem_dout),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // memory contents as seen by slot reads
  bit         fixed_en   = 1'b0;
  logic [7:0] fixed_dout = 8'h00;

  function automatic logic [7:0] mem_rd(input logic [24:0] a);
    if (fixed_en) return fixed_dout;
    return a[7:0] ^ a[23:16] ^ 8'h96;
  endfunction

  function automatic logic [7:0] exp_slot_data(input job_t j);
    if (j.exp_to || (j.addr >= j.size)) return OPEN_BUS;
    return mem_rd(j.addr);
  endfunction

  function automatic job_t mk(input logic [24:0] a, input logic [24:0] s,
                              input logic [7:0] d, input bit to);
    job_t j;
    j.addr = a; j.size = s; j.data = d; j.exp_to = to;
    return j;
  endfunction

  function automatic job_t rnd_job();
    job_t j;
    case ($urandom_range(0, 3))
      0:       j.size = '0;
      1:       j.size = 25'($urandom_range(1, 255));
      2:       j.size = 25'($urandom);
      default: j.size = 25'h1FF_FFFF;
    endcase
    case ($urandom_range(0, 3))
      0:       j.addr = (j.size != 0) ? 25'($urandom % j.size) : 25'($urandom);
      1:       j.addr = j.size;
      2:       j.addr = j.size - 25'd1;
      default: j.addr = 25'($urandom) | j.size;
    endcase
    j.data   = 8'($urandom);
    j.exp_to = 1'b0;
    return j;
  endfunction

  // SDRAM responder
  bit          mute = 1'b0, inject_ack = 1'b0, rand_dly = 1'b0;
  int          mem_dly = 3;
  bit          busy = 1'b0;
  int          cnt = 0, run = 0, last_run = 0, n_acc = 0, acc_cyc = 0;
  logic        acc_we = 1'b0;
  logic [24:0] acc_addr = '0;
  logic [7:0]  acc_din = '0;

  initial begin
    mem_ack  = 1'b0;
    mem_dout = 8'h00;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req) run++;
      else if (run > 0) begin last_run = run; run = 0; end
      if (inject_ack) begin
        mem_ack    = 1'b1;
        mem_dout   = 8'h11;
        inject_ack = 1'b0;
      end else if (!mem_req) begin
        busy = 1'b0;
      end else if (!busy) begin
        busy     = 1'b1;
        cnt      = rand_dly ? int'($urandom_range(1, 5)) : mem_dly;
        acc_we   = mem_we;
        acc_addr = mem_addr;
        acc_din  = mem_din;
        acc_cyc  = cyc;
        n_acc++;
      end else if (!mute) begin
        cnt--;
        if (cnt == 0) begin
          mem_ack  = 1'b1;
          mem_dout = mem_we ? 8'h00 : mem_rd(acc_addr);
        end
      end
    end
  end

  // requester agents: index 0 loader, 1 slot A, 2 slot B
  job_t jq [3][$];
  job_t cur [3];
  bit   pend [3];
  int   start_cyc [3];
  int   lat [3];
  int   ack_log [$];
  int   last_ack_nacc = 0;
  bit   rnd_gap = 1'b0;

  initial begin
    req_v   = '0;
    ld_data = '0;
    for (int r = 0; r < 3; r++) begin
      addr_v[r] = '0; size_v[r] = '0; pend[r] = 1'b0; start_cyc[r] = 0; lat[r] = 0;
    end
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        req_v = '0;
        for (int r = 0; r < 3; r++) pend[r] = 1'b0;
        last_ack_nacc = n_acc;
      end else begin
        for (int r = 0; r < 3; r++) begin
          bit in_rng;
          if (pend[r]) begin
            if (ack_w[r]) begin
              ack_log.push_back(r);
              lat[r] = cyc - start_cyc[r];
              if (r == 0) begin
                chk("ld_acc_cnt", n_acc - last_ack_nacc, 1);
                chk("ld_we", acc_we, 1);
                chk("ld_addr", acc_addr, cur[0].addr);
                chk("ld_din", acc_din, cur[0].data);
              end else begin
                in_rng = cur[r].addr < cur[r].size;
                chk((r == 1) ? "a_data" : "b_data", (r == 1) ? a_data : b_data,
                    exp_slot_data(cur[r]));
                chk("rd_acc_cnt", n_acc - last_ack_nacc, in_rng);
                if (in_rng) begin
                  chk("rd_we", acc_we, 0);
                  chk("rd_addr", acc_addr, cur[r].addr);
                end
              end
              last_ack_nacc = n_acc;
              req_v[r] = 1'b0;
              pend[r]  = 1'b0;
            end else if (cyc - start_cyc[r] > 400) begin
              chk("ack_wait", ack_w[r], 1);
              req_v[r] = 1'b0;
              pend[r]  = 1'b0;
            end
          end else if (jq[r].size() > 0 && !(rnd_gap && $urandom_range(0, 2) == 0)) begin
            cur[r]    = jq[r].pop_front();
            addr_v[r] = cur[r].addr;
            size_v[r] = cur[r].size;
            if (r == 0) ld_data = cur[r].data;
            req_v[r]     = 1'b1;
            pend[r]      = 1'b1;
            start_cyc[r] = cyc;
          end
        end
      end
    end
  end

  task automatic wait_all(input int budget);
    int n = 0;
    while ((jq[0].size() + jq[1].size() + jq[2].size()) != 0 || pend[0] || pend[1] || pend[2]) begin
      @(negedge clk);
      n++;
      if (n > budget) begin
        chk("drain", pend[0] | pend[1] | pend[2], 0);
        break;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  int n0;
  int n;

  initial begin
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_acks", ack_w, 0);
    chk("rst_a_data", a_data, 8'hFF);
    chk("rst_b_data", b_data, 8'hFF);
    chk("rst_timeout", timeout, 0);
    #2 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // in-range read with a 3-cycle memory
    fixed_en = 1'b1; fixed_dout = 8'h5A; mem_dly = 3;
    @(posedge clk);
    jq[1].push_back(mk(25'h0_2000, 25'h8000, 8'h00, 1'b0));
    wait_all(200);
    chk("t1_a_data", a_data, 8'h5A);
    chk("t1_mem_addr", acc_addr, 25'h0_2000);
    chk("t1_mem_we", acc_we, 0);
    chk("t1_ack_lat", lat[1], 2 + 3);
    chk("t1_req_lat", acc_cyc - start_cyc[1], 1);
    fixed_en = 1'b0;

    // boundary: addr == size
    n0 = n_acc;
    @(posedge clk);
    jq[2].push_back(mk(25'h0_8000, 25'h8000, 8'h00, 1'b0));
    wait_all(200);
    chk("t2_b_data", b_data, 8'hFF);
    chk("t2_ack_lat", lat[2], 1);
    chk("t2_no_mem", n_acc, n0);

    // loader first, then A, then B
    ack_log.delete();
    @(posedge clk);
    jq[0].push_back(mk(25'h10, 25'h0, 8'h3C, 1'b0));
    jq[1].push_back(mk(25'h100, 25'h8000, 8'h00, 1'b0));
    jq[2].push_back(mk(25'h200, 25'h8000, 8'h00, 1'b0));
    wait_all(500);
    chk("t3_cnt", ack_log.size(), 3);
    for (int i = 0; i < 3; i++) chk("t3_order", (i < ack_log.size()) ? ack_log[i] : -1, i);

    // continuous contention alternates, starting from A
    ack_log.delete();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      jq[1].push_back(mk(25'(32'h300 + i), 25'h8000, 8'h00, 1'b0));
      jq[2].push_back(mk(25'(32'h400 + i), 25'h8000, 8'h00, 1'b0));
    end
    wait_all(1000);
    chk("t4_cnt", ack_log.size(), 6);
    for (int i = 0; i < 6; i++)
      chk("t4_order", (i < ack_log.size()) ? ack_log[i] : -1, (i % 2 == 0) ? 1 : 2);

    // watchdog expiry
    mute = 1'b1;
    @(posedge clk);
    jq[1].push_back(mk(25'h300, 25'h8000, 8'h00, 1'b1));
    wait_all(300);
    chk("t5_timeout", timeout, 1);
    chk("t5_req_cycles", last_run, WDOG_CYC + 1);
    chk("t5_ack_lat", lat[1], 2 + WDOG_CYC);
    mute = 1'b0;
    @(posedge clk);
    jq[1].push_back(mk(25'h1234, 25'h8000, 8'h00, 1'b0));
    wait_all(200);
    chk("t5_after_data", a_data, 8'hA2);
    chk("t5_sticky", timeout, 1);

    // reset in the middle of WAIT
    mute = 1'b1;
    @(posedge clk);
    jq[1].push_back(mk(25'h400, 25'h8000, 8'h00, 1'b0));
    n = 0;
    while (!mem_req && n < 50) begin @(negedge clk); n++; end
    chk("t6_req_seen", mem_req, 1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_mem_req", mem_req, 0);
    chk("t6_acks", ack_w, 0);
    chk("t6_timeout", timeout, 0);
    chk("t6_a_data", a_data, 8'hFF);
    chk("t6_b_data", b_data, 8'hFF);
    chk("t6_mem_addr", mem_addr, 0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    inject_ack = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t6_late_ack", ack_w, 0);
      chk("t6_late_req", mem_req, 0);
    end
    mute = 1'b0;
    @(posedge clk);
    jq[1].push_back(mk(25'h55, 25'h100, 8'h00, 1'b0));
    wait_all(200);
    chk("t6_after_data", a_data, mem_rd(25'h55));

    // randomized mix of all three requesters
    rand_dly = 1'b1;
    rnd_gap  = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      for (int r = 0; r < 3; r++) jq[r].push_back(rnd_job());
    end
    wait_all(20000);
    chk("rnd_timeout", timeout, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
